// File: rtl/clock_ratio_meter.sv
// clock_ratio_meter: measures the I_meas_clk period in I_ref_clk cycles; define CLK_RATIO_DUTY_EN to also count the high phase
module clock_ratio_meter #(
  parameter int CNT_W = 32,
  parameter int SYNC_STAGES = 2,
  parameter longint unsigned TIMEOUT = 64'hFFFF_FFFF
) (
  input  logic I_ref_clk,
  input  logic I_rst,
  input  logic I_meas_clk,
  input  logic I_start,
  output logic o_busy,
  output logic o_valid,
  output logic [CNT_W-1:0] o_ratio,
  output logic [CNT_W-1:0] o_high_cnt,
  output logic o_timeout
);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic prev, sync, rise, at_tmo, done, tout;
  logic [CNT_W-1:0] cnt, cnt_n;
  assign sync = sync_q[SYNC_STAGES-1];
  assign rise = sync & ~prev;
  assign at_tmo = cnt == TMO;
  // the result cycle still counts as busy so a start in that cycle is visibly ignored
  assign o_busy = (state != IDLE) | o_valid;
  // synchroniser chain plus the delayed copy used for rising-edge detection
  always_ff @(posedge I_ref_clk or posedge I_rst)
    if (I_rst) begin
      sync_q <= '0;
      prev <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], I_meas_clk};
      prev <= sync;
    end
  // next state and period counter; an edge wins over a simultaneous timeout
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    done = 1'b0;
    tout = 1'b0;
    case (state)
      IDLE: if (I_start && !o_valid) begin
        state_n = ARM;
        cnt_n = '0;
      end
      ARM, MEASURE: if (rise) begin
        state_n = state == ARM ? MEASURE : IDLE;
        done = state == MEASURE;
        cnt_n = CNT_W'(1);
      end else if (at_tmo) begin
        state_n = IDLE;
        done = 1'b1;
        tout = 1'b1;
      end else cnt_n = cnt + CNT_W'(1);
      default: state_n = IDLE;
    endcase
  end
  // state, counter and result registers; results move only when a measurement completes
  always_ff @(posedge I_ref_clk or posedge I_rst)
    if (I_rst) begin
      state <= IDLE;
      cnt <= '0;
      o_valid <= 1'b0;
      o_ratio <= '0;
      o_timeout <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      o_valid <= done;
      if (done) begin
        o_ratio <= tout ? '0 : cnt;
        o_timeout <= tout;
      end
    end
`ifdef CLK_RATIO_DUTY_EN
  logic [CNT_W-1:0] hcnt, hcnt_n;
  // high-phase counter: seeded on the opening edge, then counts synchronised-high cycles
  always_comb hcnt_n = state == ARM && rise ? CNT_W'(1) :
                       state == MEASURE && !rise ? hcnt + CNT_W'(sync) : hcnt;
  // high-phase register and its reported result
  always_ff @(posedge I_ref_clk or posedge I_rst)
    if (I_rst) begin
      hcnt <= '0;
      o_high_cnt <= '0;
    end else begin
      hcnt <= hcnt_n;
      if (done) o_high_cnt <= tout ? '0 : hcnt;
    end
`else
  assign o_high_cnt = '0;
`endif
endmodule

// File: tb/tb_clock_ratio_meter.sv
// tb_clock_ratio_meter: table-driven and directed checks of clock_ratio_meter
`timescale 1ns/1ps
module tb_clock_ratio_meter;
  logic ref_clk = 1'b0, rst = 1'b1, start = 1'b0, lvl = 1'b0, aclk = 1'b0, div_clk = 1'b0;
  logic meas, busy, valid, tout;
  logic [31:0] ratio, high;
  int mode = 1, hi = 2, lo = 2, ph = 0, nvalid = 0, total = 0, passed = 0;

  clock_ratio_meter #(.CNT_W(32), .SYNC_STAGES(2), .TIMEOUT(64)) dut (
    .I_ref_clk(ref_clk), .I_rst(rst), .I_meas_clk(meas), .I_start(start),
    .o_busy(busy), .o_valid(valid), .o_ratio(ratio), .o_high_cnt(high), .o_timeout(tout)
  );

  always #5 ref_clk = ~ref_clk;
  initial begin
    #7;
    forever #50.1 aclk = ~aclk;
  end
  // synchronous divided clock: high for hi cycles, low for lo cycles
  always @(negedge ref_clk) begin
    ph = ph >= hi + lo - 1 ? 0 : ph + 1;
    div_clk = ph < hi;
  end
  assign meas = mode == 3 ? ref_clk : mode == 2 ? aclk : mode == 1 ? div_clk : lvl;
  always @(negedge ref_clk) if (valid) nvalid++;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic longint duty(input int h);
`ifdef CLK_RATIO_DUTY_EN
    return h;
`else
    return 0;
`endif
  endfunction

  // one measurement; a start is also pulsed in the result cycle, which must be ignored
  task automatic run_meas(output int lat, output logic [31:0] r, output logic [31:0] h, output logic t);
    logic [31:0] held;
    bit hold_ok;
    held = ratio;
    hold_ok = 1;
    @(negedge ref_clk) start = 1'b1;
    @(negedge ref_clk) start = 1'b0;
    chk("busy_on", busy, 1);
    lat = 0;
    while (!valid && lat < 200) begin
      if (ratio !== held) hold_ok = 0;
      @(negedge ref_clk);
      lat++;
    end
    r = ratio;
    h = high;
    t = tout;
    if (lat >= 200) chk("valid_wait", 0, 1);
    else begin
      chk("busy_in_valid", busy, 1);
      chk("result_hold", hold_ok, 1);
      start = 1'b1;
      @(negedge ref_clk) start = 1'b0;
      chk("busy_after", busy, 0);
      chk("valid_single", valid, 0);
    end
  endtask

  typedef struct {
    int mode, hi, lo;
    logic lvl;
    int er, eh, et, el;
  } vec_t;

  initial begin
    vec_t v[10];
    int lat, n0;
    logic [31:0] r, h;
    logic t;
    v[0] = '{1, 2, 2, 0, 4, 2, 0, -1};
    v[1] = '{1, 4, 3, 0, 7, 4, 0, -1};
    v[2] = '{1, 8, 8, 0, 16, 8, 0, -1};
    v[3] = '{1, 1, 1, 0, 2, 1, 0, -1};
    v[4] = '{1, 1, 2, 0, 3, 1, 0, -1};
    v[5] = '{1, 2, 5, 0, 7, 2, 0, -1};
    v[6] = '{0, 2, 2, 0, 0, 0, 1, 65};
    v[7] = '{1, 30, 30, 0, 60, 30, 0, -1};
    v[8] = '{0, 2, 2, 1, 0, 0, 1, 65};
    v[9] = '{3, 2, 2, 0, 0, 0, 1, 65};
    repeat (2) @(negedge ref_clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_ratio", ratio, 0);
    chk("rst_high", high, 0);
    chk("rst_tout", tout, 0);
    rst = 1'b0;
    repeat (3) @(negedge ref_clk);

    foreach (v[i]) begin
      mode = v[i].mode;
      hi = v[i].hi;
      lo = v[i].lo;
      lvl = v[i].lvl;
      repeat (40) @(negedge ref_clk);
      run_meas(lat, r, h, t);
      chk($sformatf("v%0d_ratio", i), r, v[i].er);
      chk($sformatf("v%0d_high", i), h, duty(v[i].eh));
      chk($sformatf("v%0d_tout", i), t, v[i].et);
      if (v[i].el >= 0) chk($sformatf("v%0d_latency", i), lat, v[i].el);
    end

    // start pulses during an active measurement are ignored
    mode = 1;
    hi = 8;
    lo = 8;
    repeat (40) @(negedge ref_clk);
    n0 = nvalid;
    @(posedge div_clk) start = 1'b1;
    @(negedge ref_clk) start = 1'b0;
    repeat (9) @(negedge ref_clk);
    start = 1'b1;
    @(negedge ref_clk) start = 1'b0;
    lat = 0;
    while (!valid && lat < 100) begin
      @(negedge ref_clk);
      lat++;
    end
    chk("restart_ratio", ratio, 16);
    repeat (40) @(negedge ref_clk);
    chk("restart_single_valid", nvalid - n0, 1);

    // asynchronous reset in the middle of a measurement
    n0 = nvalid;
    @(posedge div_clk) start = 1'b1;
    @(negedge ref_clk) start = 1'b0;
    repeat (10) @(negedge ref_clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", valid, 0);
    chk("arst_ratio", ratio, 0);
    chk("arst_high", high, 0);
    chk("arst_tout", tout, 0);
    @(negedge ref_clk) rst = 1'b0;
    repeat (40) @(negedge ref_clk);
    chk("arst_no_valid", nvalid - n0, 0);
    chk("arst_idle", busy, 0);
    hi = 2;
    lo = 2;
    repeat (40) @(negedge ref_clk);
    run_meas(lat, r, h, t);
    chk("post_rst_ratio", r, 4);
    chk("post_rst_high", h, duty(2));
    chk("post_rst_tout", t, 0);

    // asynchronous 10 MHz clock, back-to-back measurements
    mode = 2;
    repeat (40) @(negedge ref_clk);
    for (int k = 0; k < 20; k++) begin
      run_meas(lat, r, h, t);
      chk($sformatf("async%0d_range", k), (r >= 9 && r <= 11) ? 1 : 0, 1);
      chk($sformatf("async%0d_tout", k), t, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/clock_ratio_meter.md
Name: clock_ratio_meter

Overview:
- Measuring end of the integer clock divider: samples a divided or external clock (I_meas_clk) in the I_ref_clk domain.
- Measures its period in reference-clock cycles and reports the integer ratio.
- Used for divider self-check, clock-plausibility monitoring and bring-up.
- Single-shot: each I_start pulse yields exactly one result, either a valid ratio or a timeout.

Parameters:
- CNT_W, 32, width of the period counter and the ratio/high-count outputs.
- SYNC_STAGES, 2, flip-flop stages synchronising I_meas_clk into I_ref_clk (min 2).
- TIMEOUT, 32'hFFFF_FFFF, reference cycles allowed without a detected edge before aborting (≤ 2^CNT_W−1).

Ports:
- I_ref_clk  input  1  reference clock; the only clock of the block.
- I_rst  input  1  asynchronous, active-high reset.
- I_meas_clk  input  1  clock under measurement; treated as asynchronous data and never used as a clock.
- I_start  input  1  single-cycle request to start one measurement.
- o_busy  output  1  high while a measurement is in progress.
- o_valid  output  1  one-cycle pulse: a result is available.
- o_ratio  output  CNT_W  measured period in I_ref_clk cycles; holds until the next result.
- o_high_cnt  output  CNT_W  high-phase cycle count (optional feature).
- o_timeout  output  1  set with o_valid when the measurement aborted; holds until the next result.

Behaviour:
- Reset (I_rst=1, asynchronous): FSM→IDLE; synchroniser, edge register and counters cleared; o_busy=0, o_valid=0, o_ratio=0, o_high_cnt=0, o_timeout=0.
- Synchroniser: I_meas_clk passes through SYNC_STAGES flops, then one extra flop (prev).
  - Rising edge detected when sync=1 and prev=0.
  - Fixed detection latency is SYNC_STAGES+1 cycles; it cancels between the two edges.
- FSM states: IDLE, ARM, MEASURE.
- IDLE: o_busy=0. On I_start=1: cnt←0, go to ARM; o_busy=1 from the next cycle.
- ARM: wait for the first detected rising edge.
  - On edge: cnt←1, hcnt←1 if sync=1, go to MEASURE.
  - Otherwise cnt←cnt+1.
- MEASURE: on each cycle without an edge, cnt←cnt+1; hcnt←hcnt+1 when sync=1.
  - On the next detected edge: o_ratio←cnt, o_high_cnt←hcnt, o_timeout←0, o_valid=1 for one cycle, go to IDLE.
  - Example: edges 4 cycles apart give o_ratio=4.
- Timeout: in ARM or MEASURE, if cnt==TIMEOUT and no edge occurs that cycle:
  - o_ratio←0, o_high_cnt←0, o_timeout←1, o_valid=1, go to IDLE.
  - An edge in the same cycle as the timeout condition has priority (normal result).
- cnt saturates; it never wraps, because TIMEOUT bounds it.
- I_start while o_busy=1 is ignored, including the cycle that o_valid is high. A new measurement needs I_start in IDLE.
- o_ratio, o_high_cnt and o_timeout change only in the o_valid cycle or at reset.
- Measurable range:
  - Ratio ≥2 for a synchronously derived clock whose high and low phases are each ≥1 cycle.
  - Ratio ≥3 for an asynchronous clock, which has ±1 cycle sampling uncertainty.
  - Ratio 1 (I_meas_clk = I_ref_clk) is unmeasurable and ends in a timeout.
- Reset mid-measurement: immediate return to IDLE; no o_valid is produced.

Optional Feature:
- Macro: CLK_RATIO_DUTY_EN.
- Defined: the hcnt high-phase counter is built as above, and o_high_cnt reports the high cycles within the measured period.
- Undefined: no hcnt register exists; o_high_cnt is tied to 0; the port remains so the interface is unchanged.

Test Plan:
1. Assert I_rst mid-simulation with I_meas_clk toggling → all outputs 0 immediately; after release, o_busy=0 and no o_valid.
2. I_meas_clk = I_ref_clk/4 (50%, synchronous), pulse I_start → exactly one o_valid with o_ratio=4, o_timeout=0, o_high_cnt=2 (0 without CLK_RATIO_DUTY_EN); o_busy drops the cycle after o_valid.
3. Odd ratio 7 (high 4, low 3) → o_ratio=7, o_high_cnt=4; repeat with a ratio-16 clock → o_ratio=16, o_high_cnt=8.
4. TIMEOUT=64, I_meas_clk held 0, pulse I_start → o_valid with o_timeout=1 and o_ratio=0, 65 cycles after start; the previous o_ratio holds until then.
5. Pulse I_start again during MEASURE → ignored, single o_valid. Then assert I_rst during MEASURE → no o_valid; a new I_start after release measures ratio 4 correctly.
6. Asynchronous 10 MHz I_meas_clk against a 100 MHz I_ref_clk, 20 back-to-back measurements → every o_ratio in {9,10,11}, no timeouts.
